// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sequencer sharing one signed 32x32 multiplier among NREQ requesters
module mult_share_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [31:0]          mul_a,
   output logic [31:0]          mul_b,
   input  logic [63:0]          mul_p,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [63:0]          rsp_p,
   output logic                 busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] ptr, owner, grant_idx, ptr_nxt;
   logic          grant_found, grant;
   logic [3:0]    cnt;

   // Rotating priority: first pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!grant_found && req_valid[i] && (i >= int'(ptr))) begin
            grant_found = 1'b1;
            grant_idx   = PW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!grant_found && req_valid[i]) begin
            grant_found = 1'b1;
            grant_idx   = PW'(i);
         end
      end
   end

   assign ptr_nxt = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      grant     = 1'b0;
      case (state)
         IDLE: begin
            if (grant_found && !rst) begin
               grant                = 1'b1;
               req_ready[grant_idx] = 1'b1;
               state_nxt            = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready[owner]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rsp_valid = '0;
      if (state == RESP) rsp_valid[owner] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         owner <= '0;
         cnt   <= '0;
         mul_a <= '0;
         mul_b <= '0;
         rsp_p <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         if (grant) begin
            mul_a <= req_a[32*grant_idx +: 32];
            mul_b <= req_b[32*grant_idx +: 32];
            owner <= grant_idx;
            ptr   <= ptr_nxt;
            cnt   <= 4'(LAT - 1);
         end
         // Product is sampled only once the settle window has elapsed.
         if (state == WAIT) begin
            if (cnt == 4'd0) rsp_p <= mul_p;
            else             cnt   <= cnt - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - directed and randomized checks of mult_share_arbiter against a transaction-level model
module tb_mult_share_arbiter;
   localparam int NREQ = 4;
   localparam int LAT  = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
   logic [32*NREQ-1:0]   req_a, req_b;
   logic [31:0]          mul_a, mul_b;
   logic [63:0]          mul_p, rsp_p;
   logic                 busy;
   logic [63:0]          mul_a_ext, mul_b_ext;

   int n_checks = 0;
   int n_fail   = 0;

   logic [NREQ-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   always #5 clk = ~clk;

   // Stand-in for the shared multiplier: low 64 bits of the sign-extended product.
   assign mul_a_ext = {{32{mul_a[31]}}, mul_a};
   assign mul_b_ext = {{32{mul_b[31]}}, mul_b};
   assign mul_p     = mul_a_ext * mul_b_ext;

   mult_share_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_p     (rsp_p),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_age counts cycles since the grant (0 = free, LAT+1 = result offered).
   int          m_ptr = 0, m_owner = 0, m_age = 0;
   logic [31:0] m_a = '0, m_b = '0;
   logic [63:0] m_p = '0;
   bit          m_valid = 1'b0;

   function automatic int model_grant();
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NREQ;
         if (req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int              g;
      longint          pa, pb;
      logic [NREQ-1:0] e_ready, e_rspv;
      g = (m_age == 0 && !rst) ? model_grant() : -1;
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      e_rspv = '0;
      if (m_age == LAT + 1) e_rspv[m_owner] = 1'b1;
      if (m_valid) begin
         check("req_ready", 64'(req_ready), 64'(e_ready));
         check("rsp_valid", 64'(rsp_valid), 64'(e_rspv));
         check("rsp_p", rsp_p, m_p);
         check("mul_a", 64'(mul_a), 64'(m_a));
         check("mul_b", 64'(mul_b), 64'(m_b));
         check("busy", 64'(busy), 64'(m_age != 0));
      end
      if (rst) begin
         m_ptr = 0; m_owner = 0; m_age = 0;
         m_a = '0; m_b = '0; m_p = '0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (g >= 0) begin
            m_a     = req_a[32*g +: 32];
            m_b     = req_b[32*g +: 32];
            m_owner = g;
            m_ptr   = (g + 1) % NREQ;
            m_age   = 1;
         end else if (m_age >= 1 && m_age < LAT) begin
            m_age++;
         end else if (m_age == LAT) begin
            pa    = longint'($signed(m_a));
            pb    = longint'($signed(m_b));
            m_p   = 64'(pa * pb);
            m_age = LAT + 1;
         end else if (m_age == LAT + 1 && rsp_ready[m_owner]) begin
            m_age = 0;
         end
      end
   end

   task automatic wait_idle();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy && k < 30);
      check("idle timeout", 64'(busy), 64'(0));
   endtask

   task automatic single(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] p, input string tag);
      @(posedge clk); #1;
      rsp_ready = '1;
      req_a[32*idx +: 32] = a;
      req_b[32*idx +: 32] = b;
      req_valid = '0;
      req_valid[idx] = 1'b1;
      @(negedge clk); check({tag, " grant"}, 64'(req_ready), 64'(1 << idx));
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      check({tag, " mul_a"}, 64'(mul_a), 64'(a));
      check({tag, " mul_b"}, 64'(mul_b), 64'(b));
      @(negedge clk); check({tag, " early rsp"}, 64'(rsp_valid), 64'(0));
      @(negedge clk);
      check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(1 << idx));
      check({tag, " rsp_p"}, rsp_p, p);
      check({tag, " busy resp"}, 64'(busy), 64'(1));
      @(negedge clk);
      check({tag, " busy idle"}, 64'(busy), 64'(0));
      check({tag, " rsp cleared"}, 64'(rsp_valid), 64'(0));
   endtask

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'h0000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int              n_gr, last_c;
      logic [NREQ-1:0] rr;

      rst       = 1'b1;
      rsp_ready = '1;
      req_valid = '1;
      for (int i = 0; i < NREQ; i++) begin
         req_a[32*i +: 32] = 32'(i + 1);
         req_b[32*i +: 32] = 32'(10 * i + 3);
      end
      @(negedge clk); @(negedge clk);
      check("reset req_ready", 64'(req_ready), 64'(0));
      check("reset busy", 64'(busy), 64'(0));
      check("reset mul_a", 64'(mul_a), 64'(0));
      check("reset mul_b", 64'(mul_b), 64'(0));
      check("reset rsp_p", rsp_p, 64'(0));
      check("reset rsp_valid", 64'(rsp_valid), 64'(0));

      // Round-robin with every requester valid from reset.
      @(posedge clk); #1 rst = 1'b0;
      n_gr = 0;
      last_c = 0;
      for (int c = 0; c < 30 && n_gr < 5; c++) begin
         @(negedge clk);
         if (rsp_valid != '0 && n_gr > 0) check("rr rsp_valid", 64'(rsp_valid), 64'(rr_exp[n_gr-1]));
         if (req_ready != '0) begin
            check($sformatf("rr order %0d", n_gr), 64'(req_ready), 64'(rr_exp[n_gr]));
            if (n_gr > 0) check("rr spacing", 64'(c - last_c), 64'(LAT + 2));
            last_c = c;
            n_gr++;
         end
      end
      check("rr grant count", 64'(n_gr), 64'(5));
      @(posedge clk); #1 req_valid = '0;
      wait_idle();

      single(0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, "single");
      single(2, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "corner min");
      single(1, 32'h0000_0000, 32'h1234_5678, 64'h0, "corner zero");

      // Requester 1 was served last; only 3 asks, then pointer wraps to 0.
      @(posedge clk); #1;
      req_valid = 4'b1000;
      req_a[96 +: 32] = 32'd5;
      req_b[96 +: 32] = 32'hFFFF_FFFF;
      @(negedge clk); check("skip grant", 64'(req_ready), 64'(4'b1000));
      @(posedge clk); #1 req_valid = '0;
      wait_idle();
      @(posedge clk); #1 req_valid = 4'b1001;
      @(negedge clk); check("skip ptr wrap", 64'(req_ready), 64'(4'b0001));
      @(posedge clk); #1 req_valid = '0;
      wait_idle();

      // Response backpressure on requester 2 while requester 1 waits.
      @(posedge clk); #1;
      rsp_ready = 4'b1011;
      req_valid = 4'b0100;
      req_a[64 +: 32] = 32'h0001_0001;
      req_b[64 +: 32] = 32'hFFFF_0000;
      @(negedge clk); check("bp grant", 64'(req_ready), 64'(4'b0100));
      @(posedge clk); #1;
      req_valid = 4'b0010;
      req_a[32 +: 32] = 32'd9;
      req_b[32 +: 32] = 32'd11;
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp rsp_valid", 64'(rsp_valid), 64'(4'b0100));
         check("bp rsp_p", rsp_p, 64'hFFFF_FFFE_FFFF_0000);
         check("bp no grant", 64'(req_ready), 64'(0));
         @(posedge clk); #1 rsp_ready[1] = ~rsp_ready[1];
      end
      rsp_ready = '1;
      @(negedge clk);
      check("bp release rsp", 64'(rsp_valid), 64'(4'b0100));
      check("bp release no grant", 64'(req_ready), 64'(0));
      @(negedge clk); check("bp next grant", 64'(req_ready), 64'(4'b0010));
      @(posedge clk); #1 req_valid = '0;
      wait_idle();

      // Reset during WAIT discards the operation and clears the pointer.
      @(posedge clk); #1 req_valid = 4'b0100;
      @(negedge clk); check("rst grant", 64'(req_ready), 64'(4'b0100));
      @(posedge clk); #1 begin req_valid = '0; rst = 1'b1; end
      @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("rst no rsp", 64'(rsp_valid), 64'(0));
         check("rst busy", 64'(busy), 64'(0));
      end
      @(posedge clk); #1 req_valid = 4'b1001;
      @(negedge clk); check("rst ptr", 64'(req_ready), 64'(4'b0001));
      @(posedge clk); #1 req_valid = '0;
      wait_idle();

      // Random traffic: operands held until granted, occasional drops and resets.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         rr = req_ready;
         @(posedge clk); #1;
         rst = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!(req_valid[i] && !rr[i] && $urandom_range(0, 15) != 0)) begin
               req_valid[i]      = ($urandom_range(0, 2) == 0);
               req_a[32*i +: 32] = rand_op();
               req_b[32*i +: 32] = rand_op();
            end
         end
         rsp_ready = NREQ'($urandom);
      end
      @(posedge clk); #1;
      rst       = 1'b0;
      req_valid = '0;
      rsp_ready = '1;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
